serv_rf_responder: RTL and testbench
====================================

SERV_RF_RESPONDER -- requirements
Module: serv_rf_responder

Interface
REQ-001 SHALL have parameter AW, default 6: register address width; the array holds 2^AW words of 32 bits.
REQ-002 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads as 0 and writes to it are discarded.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_rf_rreq  in  1  one-cycle read request; i_rreg0/i_rreg1 valid in that cycle.
REQ-006 i_rf_wreq  in  1  one-cycle write request; i_wreg0/i_wreg1 valid in that cycle.
REQ-007 i_rreg0, i_rreg1  in  AW  read port 0/1 register addresses.
REQ-008 i_wreg0, i_wreg1  in  AW  write port 0/1 register addresses.
REQ-009 i_wen0, i_wen1  in  1  per-port write-bit strobes.
REQ-010 i_wdata0, i_wdata1  in  1  per-port serial write data, LSB first.
REQ-011 o_rf_ready  out  1  one-cycle acknowledge of a read and/or write request.
REQ-012 o_rdata0, o_rdata1  out  1  per-port serial read data, LSB first.

Function
REQ-013 Read FSM SHALL have states R_IDLE, R_ACK, R_STREAM; write FSM SHALL have states W_IDLE, W_ACK, W_CAPTURE.
REQ-014 On i_rf_rreq in cycle N, the block SHALL load both 32-bit read shift registers from the array at i_rreg0/i_rreg1 and enter R_ACK.
REQ-015 R_ACK SHALL last exactly one cycle (N+1); R_STREAM SHALL present bit k on o_rdata0/o_rdata1 in cycle N+2+k for k=0..31, then return to R_IDLE.
REQ-016 o_rdata0/o_rdata1 SHALL be 0 outside R_STREAM.
REQ-017 On i_rf_wreq in cycle N, the block SHALL latch i_wreg0/i_wreg1, clear both 5-bit bit counters, and enter W_ACK for one cycle, then W_CAPTURE.
REQ-018 o_rf_ready SHALL be 1 exactly in cycles where the read FSM or the write FSM is in R_ACK or W_ACK; simultaneous rreq and wreq SHALL yield a single one-cycle pulse.
REQ-019 In W_CAPTURE, each cycle with i_wenX=1 SHALL shift i_wdataX into port X's staging register at its counter position and increment the counter; the cycle with i_wenX=0 SHALL hold.
REQ-020 When port X captures its 32nd bit, the full word SHALL be written to the array in that edge and port X SHALL stop capturing; W_CAPTURE SHALL return to W_IDLE once both ports have committed or a new wreq arrives.
REQ-021 i_wenX outside W_CAPTURE SHALL be ignored.
REQ-022 If both ports commit to the same address in the same edge, port 1's word SHALL win.
REQ-023 A read load and a commit to the same address in the same edge SHALL return the newly committed word (write-first).
REQ-024 A read load at any later edge SHALL return the committed word; a read of a register whose write is partial SHALL return the old word.
REQ-025 i_rf_rreq during R_ACK or R_STREAM SHALL abort the current stream and restart per REQ-014.
REQ-026 i_rf_wreq during W_ACK or W_CAPTURE SHALL discard uncommitted partial words and restart per REQ-017.
REQ-027 With ZERO_REG=1, commits to address 0 SHALL be dropped and reads of address 0 SHALL stream 32 zeros.

Reset
REQ-028 While i_rst_n=0, both FSMs SHALL be in IDLE, o_rf_ready=0, o_rdata0=o_rdata1=0, counters 0, and staging registers 0.
REQ-029 Reset asserted mid-read or mid-write SHALL abort immediately; an uncommitted word SHALL never reach the array.
REQ-030 Array contents SHALL NOT be reset; they are undefined at power-up except register 0 when ZERO_REG=1.

Verification
REQ-031 wreq with wreg0=5, then 32 wen0 cycles with 0xDEADBEEF LSB first, then rreq with rreg0=5 in cycle N -> ready at N+1, o_rdata0 streams 0xDEADBEEF in cycles N+2..N+33.
REQ-032 Same-cycle rreq and wreq -> exactly one ready pulse; the read streams the old values and the write captures normally.
REQ-033 Write 0xFFFFFFFF to reg 0, then read reg 0 on both ports -> 32 zeros on o_rdata0 and o_rdata1.
REQ-034 Both ports commit reg 7 on the same edge (port0 0x1111_1111, port1 0x2222_2222) -> a subsequent read of 7 returns 0x2222_2222.
REQ-035 Write reg 3 with 0xA5A5A5A5; start a write to reg 3 with 0x0; assert i_rst_n=0 after 16 bits; release reset; read reg 3 -> 0xA5A5A5A5, and o_rf_ready=0 and o_rdata=0 throughout reset.
REQ-036 Hold wen0 low for random cycles mid-capture of 0x12345678 -> the read returns 0x12345678, and no commit occurs before the 32nd strobe.

Source files
------------

// File: rtl/serv_rf_responder.sv
// Serial register file responder: two read ports stream 32-bit words LSB first,
// two write ports capture words bit by bit and commit them to the array when complete.

module serv_rf_wlane #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          cap,
   input  logic          wen,
   input  logic          wdata,
   input  logic [AW-1:0] addr_in,
   output logic [AW-1:0] addr,
   output logic [31:0]   word,
   output logic          commit,
   output logic          done
);
   logic [31:0] stage;
   logic [4:0]  cnt;
   logic        take;

   assign take   = cap & ~done & wen;
   assign commit = take & (cnt == 5'd31);

   // The committed word carries the bit arriving on the commit edge itself.
   always_comb begin
      word     = stage;
      word[31] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         addr  <= '0;
      end else if (start) begin
         stage <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         addr  <= addr_in;
      end else if (take) begin
         stage[cnt] <= wdata;
         cnt        <= cnt + 5'd1;
         if (cnt == 5'd31)
            done <= 1'b1;
      end
   end
endmodule

module serv_rf_responder #(
   parameter int AW       = 6,
   parameter int ZERO_REG = 1
) (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic          i_rf_rreq,
   input  logic          i_rf_wreq,
   input  logic [AW-1:0] i_rreg0,
   input  logic [AW-1:0] i_rreg1,
   input  logic [AW-1:0] i_wreg0,
   input  logic [AW-1:0] i_wreg1,
   input  logic          i_wen0,
   input  logic          i_wen1,
   input  logic          i_wdata0,
   input  logic          i_wdata1,
   output logic          o_rf_ready,
   output logic          o_rdata0,
   output logic          o_rdata1
);
   localparam int DEPTH = 1 << AW;
   localparam int NP    = 2;

   typedef enum logic [1:0] {R_IDLE, R_ACK, R_STREAM}  rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_ACK, W_CAPTURE} wstate_t;

   rstate_t rstate;
   wstate_t wstate;

   logic [31:0] mem [DEPTH];

   logic [NP-1:0][AW-1:0] wreg_in, waddr;
   logic [NP-1:0]         wen, wdata, commit, done, we;
   logic [NP-1:0][31:0]   cword, rword, rsh;
   logic [4:0]            rcnt;
   logic                  cap;

   assign wreg_in = {i_wreg1, i_wreg0};
   assign wen     = {i_wen1, i_wen0};
   assign wdata   = {i_wdata1, i_wdata0};

   // A new write request pre-empts any capture still in flight.
   assign cap = (wstate == W_CAPTURE) & ~i_rf_wreq;

   generate
      for (genvar p = 0; p < NP; p++) begin : g_lane
         serv_rf_wlane #(.AW(AW)) u_lane (
            .clk     (clk),
            .rst_n   (i_rst_n),
            .start   (i_rf_wreq),
            .cap     (cap),
            .wen     (wen[p]),
            .wdata   (wdata[p]),
            .addr_in (wreg_in[p]),
            .addr    (waddr[p]),
            .word    (cword[p]),
            .commit  (commit[p]),
            .done    (done[p])
         );
         assign we[p] = commit[p] & ~((ZERO_REG != 0) && (waddr[p] == '0));
      end
   endgenerate

   // Write-first read: a commit landing on the load edge is forwarded, port 1 last so it wins.
   function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
      logic [31:0] w;
      w = mem[a];
      if (we[0] && (waddr[0] == a)) w = cword[0];
      if (we[1] && (waddr[1] == a)) w = cword[1];
      if ((ZERO_REG != 0) && (a == '0)) w = '0;
      return w;
   endfunction

   assign rword[0] = rd_word(i_rreg0);
   assign rword[1] = rd_word(i_rreg1);

   always_ff @(posedge clk) begin
      if (we[0]) mem[waddr[0]] <= cword[0];
      if (we[1]) mem[waddr[1]] <= cword[1];
   end

   // Every request lands in an ACK state next cycle, so the ack is the registered OR.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_rf_ready <= 1'b0;
      else
         o_rf_ready <= i_rf_rreq | i_rf_wreq;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rstate   <= R_IDLE;
         rsh      <= '0;
         rcnt     <= '0;
         o_rdata0 <= 1'b0;
         o_rdata1 <= 1'b0;
      end else if (i_rf_rreq) begin
         rstate   <= R_ACK;
         rsh      <= rword;
         rcnt     <= '0;
         o_rdata0 <= 1'b0;
         o_rdata1 <= 1'b0;
      end else begin
         case (rstate)
            R_ACK: begin
               rstate   <= R_STREAM;
               rcnt     <= '0;
               o_rdata0 <= rsh[0][0];
               o_rdata1 <= rsh[1][0];
               rsh[0]   <= rsh[0] >> 1;
               rsh[1]   <= rsh[1] >> 1;
            end
            R_STREAM: begin
               if (rcnt == 5'd31) begin
                  rstate   <= R_IDLE;
                  o_rdata0 <= 1'b0;
                  o_rdata1 <= 1'b0;
               end else begin
                  rcnt     <= rcnt + 5'd1;
                  o_rdata0 <= rsh[0][0];
                  o_rdata1 <= rsh[1][0];
                  rsh[0]   <= rsh[0] >> 1;
                  rsh[1]   <= rsh[1] >> 1;
               end
            end
            default: begin
               rstate   <= R_IDLE;
               o_rdata0 <= 1'b0;
               o_rdata1 <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)
         wstate <= W_IDLE;
      else if (i_rf_wreq)
         wstate <= W_ACK;
      else begin
         case (wstate)
            W_ACK:     wstate <= W_CAPTURE;
            W_CAPTURE: if (&(done | commit)) wstate <= W_IDLE;
            default:   wstate <= W_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serv_rf_responder.sv
// Scoreboard bench for serv_rf_responder: stimulus queues expected acks/streams,
// a negedge monitor pops and compares them.

module tb_serv_rf_responder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       rreq, wreq;
   logic [5:0] rreg0, rreg1, wreg0, wreg1;
   logic       wen0, wen1, wdata0, wdata1;
   logic       o_rf_ready, o_rdata0, o_rdata1;

   serv_rf_responder #(.AW(6), .ZERO_REG(1)) dut (
      .clk        (clk),
      .i_rst_n    (rst_n),
      .i_rf_rreq  (rreq),
      .i_rf_wreq  (wreq),
      .i_rreg0    (rreg0),
      .i_rreg1    (rreg1),
      .i_wreg0    (wreg0),
      .i_wreg1    (wreg1),
      .i_wen0     (wen0),
      .i_wen1     (wen1),
      .i_wdata0   (wdata0),
      .i_wdata1   (wdata1),
      .o_rf_ready (o_rf_ready),
      .o_rdata0   (o_rdata0),
      .o_rdata1   (o_rdata1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          rd;
      logic [31:0] d0;
      logic [31:0] d1;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0, n_tot = 0;
   int   idle_viol = 0, rst_viol = 0;
   bit   streaming = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tot++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
   endtask

   // Monitor: pops one expectation per ack pulse and collects the 32-bit streams.
   initial begin
      exp_t        cur, e;
      int          bi;
      logic [31:0] got0, got1;
      bi = 0; got0 = '0; got1 = '0;
      cur.cyc = 0; cur.rd = 0; cur.d0 = '0; cur.d1 = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            if (o_rf_ready !== 1'b0 || o_rdata0 !== 1'b0 || o_rdata1 !== 1'b0) rst_viol++;
            streaming = 0;
         end else begin
            if (streaming) begin
               got0[bi] = o_rdata0;
               got1[bi] = o_rdata1;
               bi++;
               if (bi == 32) begin
                  streaming = 0;
                  chk("rdata0_word", got0, cur.d0);
                  chk("rdata1_word", got1, cur.d1);
               end
            end else if (o_rdata0 !== 1'b0 || o_rdata1 !== 1'b0) idle_viol++;
            if (o_rf_ready === 1'b1) begin
               if (exp_q.size() == 0) chk("ready_unexpected", {31'b0, o_rf_ready}, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  chk("ready_cycle", cyc, e.cyc);
                  if (e.rd) begin
                     cur = e;
                     streaming = 1;
                     bi = 0;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rreq = 0; wreq = 0; wen0 = 0; wen1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   task automatic push(input bit rd, input logic [31:0] d0, input logic [31:0] d1);
      exp_t e;
      e.cyc = cyc + 1; e.rd = rd; e.d0 = d0; e.d1 = d1;
      exp_q.push_back(e);
   endtask

   // Request cycle, then the ack cycle driven with strobes that must be ignored.
   task automatic start_wr(input logic [5:0] a0, input logic [5:0] a1, input bit push_it);
      wreq = 1; wreg0 = a0; wreg1 = a1;
      if (push_it) push(0, '0, '0);
      tick();
      wen0 = 1; wen1 = 1; wdata0 = 1; wdata1 = 1;
      tick();
   endtask

   task automatic wr_bits(input logic [31:0] d0, input logic [31:0] d1, input bit e0,
                          input bit e1, input int lo, input int hi, input int maxgap);
      for (int b = lo; b <= hi; b++) begin
         repeat ($urandom_range(maxgap, 0)) tick();
         wen0 = e0; wdata0 = d0[b];
         wen1 = e1; wdata1 = d1[b];
         tick();
      end
   endtask

   task automatic wr(input logic [5:0] a0, input logic [5:0] a1, input logic [31:0] d0,
                     input logic [31:0] d1, input bit e0, input bit e1);
      start_wr(a0, a1, 1);
      wr_bits(d0, d1, e0, e1, 0, 31, 0);
      tick();
   endtask

   task automatic rd(input logic [5:0] a0, input logic [5:0] a1,
                     input logic [31:0] x0, input logic [31:0] x1);
      rreq = 1; rreg0 = a0; rreg1 = a1;
      push(1, x0, x1);
      tick();
      repeat (33) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      rst_n = 1; rreq = 0; wreq = 0; wen0 = 0; wen1 = 0; wdata0 = 0; wdata1 = 0;
      rreg0 = 0; rreg1 = 0; wreg0 = 0; wreg1 = 0;
      #2 rst_n = 0;
      #1;
      chk("reset_ready",  {31'b0, o_rf_ready}, 32'd0);
      chk("reset_rdata0", {31'b0, o_rdata0},   32'd0);
      chk("reset_rdata1", {31'b0, o_rdata1},   32'd0);
      repeat (3) tick();
      rst_n = 1;
      tick();

      // Basic write/read, port 1 reading the zero register
      wr(6'd5, 6'd0, 32'hDEADBEEF, 32'h0, 1, 0);
      rd(6'd5, 6'd0, 32'hDEADBEEF, 32'h0);

      // Same-edge commit from both ports: port 1 wins
      wr(6'd7, 6'd7, 32'h11111111, 32'h22222222, 1, 1);
      rd(6'd7, 6'd5, 32'h22222222, 32'hDEADBEEF);

      // Writes to register 0 are dropped
      wr(6'd0, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1);
      rd(6'd0, 6'd0, 32'h0, 32'h0);

      // Simultaneous read and write: one ack, read returns old data
      rreq = 1; rreg0 = 6'd5; rreg1 = 6'd7;
      push(1, 32'hDEADBEEF, 32'h22222222);
      start_wr(6'd5, 6'd6, 0);
      wr_bits(32'h0BADC0DE, 32'h600D600D, 1, 1, 0, 31, 0);
      tick();
      rd(6'd5, 6'd6, 32'h0BADC0DE, 32'h600D600D);

      // Read load on the commit edge returns the new word
      d = 32'h8F0F1234;
      start_wr(6'd12, 6'd0, 1);
      wr_bits(d, 32'h0, 1, 0, 0, 30, 0);
      wen0 = 1; wdata0 = d[31];
      rreq = 1; rreg0 = 6'd12; rreg1 = 6'd12;
      push(1, d, d);
      tick();
      repeat (33) tick();

      // Gapped capture: partial word is invisible, complete word lands after bit 31
      wr(6'd9, 6'd0, 32'hCAFEF00D, 32'h0, 1, 0);
      start_wr(6'd9, 6'd0, 1);
      wr_bits(32'h12345678, 32'h0, 1, 0, 0, 30, 3);
      rd(6'd9, 6'd9, 32'hCAFEF00D, 32'hCAFEF00D);
      wr_bits(32'h12345678, 32'h0, 1, 0, 31, 31, 2);
      tick();
      rd(6'd9, 6'd9, 32'h12345678, 32'h12345678);

      // Reset mid-write: the partial word never reaches the array
      wr(6'd3, 6'd0, 32'hA5A5A5A5, 32'h0, 1, 0);
      start_wr(6'd3, 6'd0, 1);
      wr_bits(32'h0, 32'h0, 1, 0, 0, 15, 0);
      rst_n = 0;
      #1;
      chk("midwr_reset_ready",  {31'b0, o_rf_ready}, 32'd0);
      chk("midwr_reset_rdata0", {31'b0, o_rdata0},   32'd0);
      repeat (3) tick();
      rst_n = 1;
      tick();
      rd(6'd3, 6'd3, 32'hA5A5A5A5, 32'hA5A5A5A5);

      repeat (3) tick();
      chk("queue_empty",     exp_q.size(), 32'd0);
      chk("stream_finished", {31'b0, streaming}, 32'd0);
      chk("idle_rdata_zero", idle_viol, 32'd0);
      chk("reset_quiet",     rst_viol, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
